// File: rtl/centroid_ctrl_if.sv
// Stream-in / result-out bundle for centroid_ctrl.
// master drives the video stream and observes results; slave is the tracker.
interface centroid_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             de_in;
    logic             h_sync_in;
    logic             v_sync_in;
    logic [23:0]      pixel_in;
    logic [11:0]      x;
    logic [11:0]      y;
    logic             valid;
    logic             no_obj;
    logic [CNT_W-1:0] obj_cnt;
    logic             overrun;

    modport master (
        output de_in, h_sync_in, v_sync_in, pixel_in,
        input  x, y, valid, no_obj, obj_cnt, overrun
    );

    modport slave (
        input  de_in, h_sync_in, v_sync_in, pixel_in,
        output x, y, valid, no_obj, obj_cnt, overrun
    );
endinterface

// File: rtl/centroid_ctrl.sv
// Per-frame mask centroid: accumulates moments during active video, then one
// shared restoring divider produces row mean (x) and column mean (y).
module centroid_ctrl #(
    parameter int         IMG_H  = 64,
    parameter int         IMG_W  = 64,
    parameter logic [7:0] THRESH = 8'h80,
    parameter int         SUM_W  = 32,
    parameter int         CNT_W  = 24
) (
    input  logic      clk,
    input  logic      rst,
    centroid_ctrl_if.slave bus
);
    localparam int BC_W = $clog2(SUM_W);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} state_t;

    state_t state_q, state_d;

    logic             v_sync_d_q;
    logic [11:0]      col_q, row_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W-1:0] sum_r_q, sum_c_q;

    logic [CNT_W-1:0] div_cnt_q;
    logic [SUM_W-1:0] snap_c_q;
    logic [SUM_W-1:0] dvd_q, quo_q;
    logic [CNT_W-1:0] rem_q;
    logic [BC_W-1:0]  bit_q;
    logic [11:0]      qx_q;

    logic [11:0]      x_q, y_q;
    logic             valid_q, no_obj_q, ovr_pend_q, overrun_q;
    logic [CNT_W-1:0] obj_cnt_q;

    logic             frame_end, is_obj, acc_en, cnt_zero, last_bit;
    logic             load_snap, step, switch_y, publish;
    logic [CNT_W:0]   rem_sh;
    logic             ge;
    logic [CNT_W-1:0] rem_nx;
    logic [SUM_W-1:0] quo_nx;
    logic             unused_inputs;

    function automatic logic [11:0] sat12(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:12]) ? 12'hFFF : q[11:0];
    endfunction

    assign unused_inputs = ^{bus.h_sync_in, bus.pixel_in[15:0]};

    assign frame_end = bus.v_sync_in & ~v_sync_d_q;
    assign is_obj    = (bus.pixel_in[23:16] >= THRESH);
    assign acc_en    = ~bus.v_sync_in & bus.de_in & is_obj;
    assign cnt_zero  = (cnt_q == '0);
    assign last_bit  = (bit_q == BC_W'(SUM_W - 1));

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign rem_sh = {rem_q, dvd_q[SUM_W-1]};
    assign ge     = (rem_sh >= {1'b0, div_cnt_q});
    assign rem_nx = ge ? CNT_W'(rem_sh - {1'b0, div_cnt_q}) : CNT_W'(rem_sh);
    assign quo_nx = {quo_q[SUM_W-2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A frame end restarts the pipeline from any state, discarding work in flight.
    always_comb begin
        state_d = state_q;
        if (frame_end) begin
            state_d = cnt_zero ? PUBLISH : DIV_X;
        end else begin
            case (state_q)
                DIV_X:   if (last_bit) state_d = DIV_Y;
                DIV_Y:   if (last_bit) state_d = PUBLISH;
                PUBLISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_snap = frame_end;
        step      = ~frame_end & ((state_q == DIV_X) | (state_q == DIV_Y));
        switch_y  = step & (state_q == DIV_X) & last_bit;
        publish   = ~frame_end & (state_q == PUBLISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_sync_d_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            v_sync_d_q <= bus.v_sync_in;
            if (bus.v_sync_in) begin
                col_q <= '0;
                row_q <= '0;
            end else if (bus.de_in) begin
                if (col_q == 12'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == 12'(IMG_H - 1)) ? 12'd0 : row_q + 12'd1;
                end else begin
                    col_q <= col_q + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            cnt_q   <= '0;
            sum_r_q <= '0;
            sum_c_q <= '0;
        end else if (acc_en) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            sum_r_q <= sum_r_q + SUM_W'(row_q);
            sum_c_q <= sum_c_q + SUM_W'(col_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            snap_c_q  <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            bit_q     <= '0;
            qx_q      <= '0;
        end else if (load_snap) begin
            div_cnt_q <= cnt_q;
            snap_c_q  <= sum_c_q;
            dvd_q     <= sum_r_q;
            quo_q     <= '0;
            rem_q     <= '0;
            bit_q     <= '0;
        end else if (switch_y) begin
            qx_q  <= sat12(quo_nx);
            dvd_q <= snap_c_q;
            quo_q <= '0;
            rem_q <= '0;
            bit_q <= '0;
        end else if (step) begin
            dvd_q <= {dvd_q[SUM_W-2:0], 1'b0};
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            bit_q <= last_bit ? '0 : bit_q + BC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            no_obj_q   <= 1'b1;
            obj_cnt_q  <= '0;
            ovr_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q    <= publish;
            ovr_pend_q <= frame_end & (state_q != IDLE);
            overrun_q  <= ovr_pend_q;
            if (publish) begin
                if (div_cnt_q == '0) begin
                    no_obj_q  <= 1'b1;
                    obj_cnt_q <= '0;
                end else begin
                    no_obj_q  <= 1'b0;
                    obj_cnt_q <= div_cnt_q;
                    x_q       <= qx_q;
                    y_q       <= sat12(quo_q);
                end
            end
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.valid   = valid_q;
    assign bus.no_obj  = no_obj_q;
    assign bus.obj_cnt = obj_cnt_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_centroid_ctrl.sv
// Directed frames with hand-computed centroids; a monitor checks every valid
// and overrun pulse against the scoreboard queues, including exact latency.
module tb_centroid_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
        int cnt;
        int nobj;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];

    centroid_ctrl_if #(.CNT_W(24)) bus ();

    centroid_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pix(input bit obj, input int r, input int c);
        logic [15:0] noise;
        noise = 16'($urandom);
        if (obj) return {(((r + c) % 2) == 1) ? 8'h80 : 8'hFF, noise};
        return {(((r + c) % 2) == 1) ? 8'h7F : 8'h00, noise};
    endfunction

    task automatic run_frame(input int r0, input int r1, input int c0, input int c1);
        bus.v_sync_in = 1'b0;
        bus.de_in     = 1'b0;
        tick();
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
                bus.de_in    = 1'b1;
                bus.pixel_in = pix(r >= r0 && r <= r1 && c >= c0 && c <= c1, r, c);
                tick();
            end
            bus.de_in = 1'b0;
            repeat (3) tick();
        end
    endtask

    // The de pulse with an object pixel during v_sync must be ignored.
    task automatic raise_vsync(output int e);
        bus.v_sync_in = 1'b1;
        bus.de_in     = 1'b1;
        bus.pixel_in  = 24'hFF_FFFF;
        e = cyc + 1;
        tick();
        bus.de_in = 1'b0;
    endtask

    task automatic push_exp(input int c, input int x, input int y, input int n, input int nobj);
        exp_t t;
        t.cyc = c; t.x = x; t.y = y; t.cnt = n; t.nobj = nobj;
        exp_q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t t;
                    t = exp_q.pop_front();
                    check("valid_cycle", cyc, t.cyc);
                    check("x", bus.x, t.x);
                    check("y", bus.y, t.y);
                    check("obj_cnt", bus.obj_cnt, t.cnt);
                    check("no_obj", bus.no_obj, t.nobj);
                    $display("result @%0d: x=%0d y=%0d obj_cnt=%0d no_obj=%0d",
                             cyc, bus.x, bus.y, bus.obj_cnt, bus.no_obj);
                end
            end
            if (bus.overrun) begin
                if (ovr_q.size() == 0) begin
                    check("unexpected_overrun", 1, 0);
                end else begin
                    check("overrun_cycle", cyc, ovr_q.pop_front());
                    $display("overrun @%0d", cyc);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"},       bus.x, 0);
        check({tag, "_y"},       bus.y, 0);
        check({tag, "_valid"},   bus.valid, 0);
        check({tag, "_no_obj"},  bus.no_obj, 1);
        check({tag, "_obj_cnt"}, bus.obj_cnt, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e1, e2, guard;
        bus.de_in     = 1'b0;
        bus.h_sync_in = 1'b0;
        bus.v_sync_in = 1'b0;
        bus.pixel_in  = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // 4x4 square: sum_r=184, sum_c=344, cnt=16
        run_frame(10, 13, 20, 23);
        raise_vsync(e); push_exp(e + 65, 11, 21, 16, 0);
        repeat (6) tick();

        // empty frame: x/y held from the square
        run_frame(1, 0, 1, 0);
        raise_vsync(e); push_exp(e + 1, 11, 21, 0, 1);
        repeat (6) tick();

        run_frame(63, 63, 63, 63);
        raise_vsync(e); push_exp(e + 65, 63, 63, 1, 0);
        repeat (6) tick();

        run_frame(0, 0, 0, 0);
        raise_vsync(e); push_exp(e + 65, 0, 0, 1, 0);
        repeat (6) tick();

        // overrun: second frame end 20 clocks later, object row 0 cols 0..1
        run_frame(10, 13, 20, 23);
        raise_vsync(e1);
        ovr_q.push_back(e1 + 21);
        repeat (2) tick();
        bus.v_sync_in = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.de_in    = 1'b1;
            bus.pixel_in = pix(c < 2, 0, c);
            tick();
        end
        bus.de_in = 1'b0;
        while (cyc < e1 + 19) tick();
        raise_vsync(e2);
        push_exp(e2 + 65, 0, 0, 2, 0);
        repeat (6) tick();

        // reset 30 clocks into DIV_X: no result may appear
        run_frame(10, 13, 20, 23);
        raise_vsync(e);
        repeat (3) tick();
        bus.v_sync_in = 1'b0;
        while (cyc < e + 29) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_div_reset");
        rst = 1'b0;
        repeat (80) tick();
        check_reset_outputs("after_reset");

        // full frame: sum = 2016*64 = 129024, /4096 = 31
        run_frame(0, 63, 0, 63);
        raise_vsync(e); push_exp(e + 65, 31, 31, 4096, 0);
        repeat (6) tick();

        guard = 0;
        while ((exp_q.size() != 0 || ovr_q.size() != 0) && guard < 300) begin
            tick();
            guard++;
        end
        check("pending_results", exp_q.size(), 0);
        check("pending_overruns", ovr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
